// File: rtl/l2_port_arbiter.sv
// Shares the single L2 port between the I-cache and D-cache miss interfaces.
// One transaction is outstanding at a time. Each completion is followed by a one-cycle mask.
module l2_port_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         proc_reset,
    input  logic         i_read,
    input  logic [29:0]  i_addr,
    output logic [127:0] i_rdata,
    output logic         i_ready,
    input  logic         d_read,
    input  logic         d_write,
    input  logic [29:0]  d_addr,
    input  logic [31:0]  d_wdata,
    output logic [127:0] d_rdata,
    output logic         d_ready,
    output logic         l2_read,
    output logic         l2_write,
    output logic [29:0]  l2_addr,
    output logic [31:0]  l2_wdata,
    input  logic [127:0] l2_rdata,
    input  logic         l2_ready,
    output logic         err
);

    // state  | meaning
    // IDLE   | no grant; arbitrate the live requests
    // I_BUSY | I-cache owns the L2 port
    // D_BUSY | D-cache owns the L2 port
    // HOLD   | one-cycle mask for the stale request that follows a completion
    typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, HOLD} state_t;

    localparam logic [15:0] ERR_CNT = 16'(TIMEOUT - 1);

    state_t      state;
    logic        last_d;
    logic [15:0] busy_cnt;
    logic        i_req;
    logic        d_req;

    assign i_req = i_read;
    assign d_req = d_read | d_write;

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state    <= IDLE;
            last_d   <= 1'b0;
            busy_cnt <= 16'd0;
            err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // On a contest, the requester not served last wins.
                    if (i_req && (!d_req || last_d)) begin
                        state    <= I_BUSY;
                        busy_cnt <= 16'd0;
                    end else if (d_req) begin
                        state    <= D_BUSY;
                        busy_cnt <= 16'd0;
                    end
                end
                I_BUSY, D_BUSY: begin
                    if (busy_cnt == ERR_CNT) begin
                        err <= 1'b1;
                    end
                    if (l2_ready) begin
                        state  <= HOLD;
                        last_d <= (state == D_BUSY);
                    end else if (busy_cnt != 16'hFFFF) begin
                        busy_cnt <= busy_cnt + 16'd1;
                    end
                end
                HOLD: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Commands follow the live request level of the current owner.
    always_comb begin
        l2_read  = 1'b0;
        l2_write = 1'b0;
        l2_addr  = 30'd0;
        l2_wdata = 32'd0;
        i_ready  = 1'b0;
        i_rdata  = 128'd0;
        d_ready  = 1'b0;
        d_rdata  = 128'd0;
        case (state)
            I_BUSY: begin
                l2_read = i_read;
                l2_addr = i_addr;
                if (l2_ready) begin
                    i_ready = 1'b1;
                    i_rdata = l2_rdata;
                end
            end
            D_BUSY: begin
                l2_write = d_write;
                l2_read  = d_read & ~d_write;
                l2_addr  = d_addr;
                l2_wdata = d_wdata;
                if (l2_ready) begin
                    d_ready = 1'b1;
                    d_rdata = l2_rdata;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Directed bench for l2_port_arbiter with hand-computed expectations per cycle.
module tb_l2_port_arbiter;

    logic         clk = 1'b0;
    logic         proc_reset;
    logic         i_read;
    logic [29:0]  i_addr;
    logic [127:0] i_rdata;
    logic         i_ready;
    logic         d_read;
    logic         d_write;
    logic [29:0]  d_addr;
    logic [31:0]  d_wdata;
    logic [127:0] d_rdata;
    logic         d_ready;
    logic         l2_read;
    logic         l2_write;
    logic [29:0]  l2_addr;
    logic [31:0]  l2_wdata;
    logic [127:0] l2_rdata;
    logic         l2_ready;
    logic         err;

    int n_run  = 0;
    int n_fail = 0;

    localparam logic [127:0] PAT_A5 = {16{8'hA5}};
    localparam logic [127:0] PAT_3C = {16{8'h3C}};

    l2_port_arbiter #(.TIMEOUT(8)) dut (
        .clk(clk), .proc_reset(proc_reset),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .l2_read(l2_read), .l2_write(l2_write), .l2_addr(l2_addr), .l2_wdata(l2_wdata),
        .l2_rdata(l2_rdata), .l2_ready(l2_ready), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_run++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        proc_reset = 1'b1;
        i_read = 1'b0; i_addr = '0;
        d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
        l2_ready = 1'b0; l2_rdata = '0;
        tick();
        tick();
        proc_reset = 1'b0;
    endtask

    initial begin
        // Reset state: everything 0, stray l2_ready in IDLE ignored
        do_reset();
        l2_ready = 1'b1; l2_rdata = PAT_3C;
        #1;
        chk("rst_l2_read", l2_read, 0);
        chk("rst_l2_write", l2_write, 0);
        chk("rst_l2_addr", l2_addr, 0);
        chk("rst_i_ready", i_ready, 0);
        chk("rst_d_ready", d_ready, 0);
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_err", err, 0);

        // Lone I read: command cycles 2..5, ready in 5, masked in 6
        do_reset();
        i_read = 1'b1; i_addr = 30'h100;
        #1;
        chk("li_c1_l2_read", l2_read, 0);
        for (int c = 2; c <= 5; c++) begin
            tick();
            if (c == 5) begin l2_ready = 1'b1; l2_rdata = PAT_A5; end
            #1;
            chk("li_l2_read", l2_read, 1);
            chk("li_l2_addr", l2_addr, 30'h100);
            chk("li_l2_write", l2_write, 0);
            chk("li_i_ready", i_ready, (c == 5));
            chk("li_i_rdata", i_rdata, (c == 5) ? PAT_A5 : 128'd0);
            chk("li_d_ready", d_ready, 0);
        end
        tick();
        l2_ready = 1'b1;
        #1;
        chk("li_hold_l2_read", l2_read, 0);
        chk("li_hold_i_ready", i_ready, 0);
        chk("li_hold_i_rdata", i_rdata, 0);
        l2_ready = 1'b0; i_read = 1'b0;
        tick(); #1;
        chk("li_idle_l2_read", l2_read, 0);

        // Contest: D, then I, then D again
        do_reset();
        i_read = 1'b1; i_addr = 30'h11; d_read = 1'b1; d_addr = 30'h22;
        tick(); #1;
        chk("ct1_l2_addr", l2_addr, 30'h22);
        chk("ct1_l2_read", l2_read, 1);
        tick(); l2_ready = 1'b1; #1;
        chk("ct1_d_ready", d_ready, 1);
        chk("ct1_i_ready", i_ready, 0);
        tick(); l2_ready = 1'b0; #1;
        chk("ct1_hold", l2_read, 0);
        tick(); #1;
        chk("ct1_idle", l2_read, 0);
        tick(); #1;
        chk("ct2_l2_addr", l2_addr, 30'h11);
        chk("ct2_l2_read", l2_read, 1);
        tick(); l2_ready = 1'b1; #1;
        chk("ct2_i_ready", i_ready, 1);
        chk("ct2_d_ready", d_ready, 0);
        tick(); l2_ready = 1'b0;
        tick();
        tick(); #1;
        chk("ct3_l2_addr", l2_addr, 30'h22);
        tick(); l2_ready = 1'b1; #1;
        chk("ct3_d_ready", d_ready, 1);
        tick(); l2_ready = 1'b0; i_read = 1'b0; d_read = 1'b0;

        // Dirty writeback then refill
        do_reset();
        d_write = 1'b1; d_addr = 30'h2A; d_wdata = 32'hDEADBEEF;
        #1;
        chk("wb_c1_l2_write", l2_write, 0);
        for (int c = 2; c <= 4; c++) begin
            tick();
            if (c == 4) l2_ready = 1'b1;
            #1;
            chk("wb_l2_write", l2_write, 1);
            chk("wb_l2_read", l2_read, 0);
            chk("wb_l2_wdata", l2_wdata, 32'hDEADBEEF);
            chk("wb_d_ready", d_ready, (c == 4));
        end
        tick(); l2_ready = 1'b0; d_write = 1'b0; d_read = 1'b1; #1;
        chk("wb_c5_cmd", {l2_read, l2_write}, 2'b00);
        tick(); #1;
        chk("wb_c6_cmd", {l2_read, l2_write}, 2'b00);
        tick(); #1;
        chk("wb_c7_l2_read", l2_read, 1);
        chk("wb_c7_l2_addr", l2_addr, 30'h2A);
        tick(); l2_ready = 1'b1; l2_rdata = PAT_3C; #1;
        chk("wb_refill_rdata", d_rdata, PAT_3C);

        // D read/write conflict: write wins
        tick(); l2_ready = 1'b0; d_write = 1'b1;
        tick();
        tick(); #1;
        chk("rw_l2_write", l2_write, 1);
        chk("rw_l2_read", l2_read, 0);
        tick(); l2_ready = 1'b1; #1;
        chk("rw_d_ready", d_ready, 1);
        tick(); l2_ready = 1'b0; d_read = 1'b0; d_write = 1'b0;

        // Watchdog with TIMEOUT=8
        do_reset();
        d_read = 1'b1; d_addr = 30'h33;
        for (int b = 1; b <= 9; b++) begin
            tick(); #1;
            if (b == 6) chk("wd_err_early", err, 0);
            if (b == 9) chk("wd_err_set", err, 1);
        end
        repeat (20) tick();
        #1;
        chk("wd_err_sticky", err, 1);
        chk("wd_still_granted", l2_read, 1);
        tick(); l2_ready = 1'b1; l2_rdata = PAT_A5; #1;
        chk("wd_late_ready", d_ready, 1);
        chk("wd_late_rdata", d_rdata, PAT_A5);
        tick(); l2_ready = 1'b0; d_read = 1'b0; #1;
        chk("wd_err_after", err, 1);

        // Mid-transaction reset with D pending
        do_reset();
        #1;
        chk("mr_err_cleared", err, 0);
        i_read = 1'b1; i_addr = 30'h44;
        tick();
        tick();
        tick();
        d_read = 1'b1; d_addr = 30'h55; proc_reset = 1'b1;
        #1;
        chk("mr_pre_l2_addr", l2_addr, 30'h44);
        tick();
        proc_reset = 1'b0; l2_ready = 1'b1; l2_rdata = PAT_A5;
        #1;
        chk("mr_cmd_zero", {l2_read, l2_write}, 2'b00);
        chk("mr_addr_zero", l2_addr, 0);
        chk("mr_ready_zero", {i_ready, d_ready}, 2'b00);
        chk("mr_rdata_zero", i_rdata | d_rdata, 0);
        l2_ready = 1'b0;
        tick(); #1;
        chk("mr_d_wins_addr", l2_addr, 30'h55);
        chk("mr_d_wins_read", l2_read, 1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
